// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the fetch/data memory arbiter.
package mem_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 32;
    localparam int unsigned DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_I = 2'd1,
        OWN_D = 2'd2
    } state_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts fetch denials; raises force_fetch once LIMIT consecutive denials accrue.
module mem_arb_starve_ctr
#(
    parameter int unsigned LIMIT = 4
)
(
    input  logic clk,
    input  logic rst,
    input  logic deny,
    input  logic grant,
    output logic force_fetch
);

    localparam int unsigned CNT_W = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (grant) begin
            cnt_d = '0;
        end else if (deny && (cnt_q != CNT_W'(LIMIT))) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            force_fetch <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            force_fetch <= (cnt_d == CNT_W'(LIMIT));
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data requesters, one transaction in flight.
// Define MEM_ARB_STARVE_GUARD_EN to let a starved fetch win after STARVE_LIMIT denials.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned STARVE_LIMIT = 4
)
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_gnt,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                m_req,
    output logic                m_we,
    output logic [DATA_W/8-1:0] m_be,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    input  logic                m_ready,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata
);

    state_t state_q;
    state_t state_d;
    logic   arb_en;
    logic   pick_d;
    logic   pick_i;
    logic   force_fetch;

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(
        .LIMIT       (STARVE_LIMIT)
    ) u_starve_ctr (
        .clk         (clk),
        .rst         (rst),
        .deny        (d_gnt & i_req),
        .grant       (i_gnt),
        .force_fetch (force_fetch)
    );
`else
    // Limit only matters when the guard is built in; fetch is never forced here.
    assign force_fetch = 1'b0 && (STARVE_LIMIT != 0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Response return, arbitration and memory request; everything held at 0 during reset.
    always_comb begin
        state_d  = state_q;
        arb_en   = 1'b0;
        pick_d   = 1'b0;
        pick_i   = 1'b0;
        i_gnt    = 1'b0;
        i_rvalid = 1'b0;
        i_rdata  = '0;
        d_gnt    = 1'b0;
        d_rvalid = 1'b0;
        d_rdata  = '0;
        m_req    = 1'b0;
        m_we     = 1'b0;
        m_be     = '0;
        m_addr   = '0;
        m_wdata  = '0;

        if (!rst) begin
            case (state_q)
                IDLE: arb_en = 1'b1;
                OWN_I: begin
                    if (m_rvalid) begin
                        i_rvalid = 1'b1;
                        i_rdata  = m_rdata;
                        arb_en   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                OWN_D: begin
                    if (m_rvalid) begin
                        d_rvalid = 1'b1;
                        d_rdata  = m_rdata;
                        arb_en   = 1'b1;
                        state_d  = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (arb_en) begin
                pick_d = d_req && !(i_req && force_fetch);
                pick_i = i_req && !pick_d;
                if (pick_d) begin
                    m_req   = 1'b1;
                    m_we    = d_we;
                    m_be    = d_be;
                    m_addr  = d_addr;
                    m_wdata = d_wdata;
                    if (m_ready) begin
                        d_gnt   = 1'b1;
                        state_d = OWN_D;
                    end
                end else if (pick_i) begin
                    m_req  = 1'b1;
                    m_be   = '1;
                    m_addr = i_addr;
                    if (m_ready) begin
                        i_gnt   = 1'b1;
                        state_d = OWN_I;
                    end
                end
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 SHALL have parameter STARVE_LIMIT, 4, consecutive denied arbitration cycles before fetch is forced.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have fetch ports i_req in 1, i_addr in ADDR_W, i_gnt out 1, i_rvalid out 1, i_rdata out DATA_W.
REQ-007 SHALL have data ports d_req in 1, d_we in 1, d_be in DATA_W/8, d_addr in ADDR_W, d_wdata in DATA_W, d_gnt out 1, d_rvalid out 1, d_rdata out DATA_W.
REQ-008 SHALL have memory ports m_req out 1, m_we out 1, m_be out DATA_W/8, m_addr out ADDR_W, m_wdata out DATA_W, m_ready in 1, m_rvalid in 1, m_rdata in DATA_W.

Function
REQ-009 SHALL share one single-port memory between the fetch and data requesters, with at most one transaction outstanding.
REQ-010 SHALL implement FSM states IDLE, OWN_I and OWN_D, with OWN_x meaning the transaction for requester x was accepted and its response is pending.
REQ-011 SHALL arbitrate combinationally in IDLE, and in OWN_x during the cycle m_rvalid=1: data beats fetch unless the starvation guard is active (REQ-022).
REQ-012 SHALL drive m_req and the winner's m_we/m_be/m_addr/m_wdata in the arbitration cycle; fetch forces m_we=0 and m_be=all-ones.
REQ-013 SHALL assert the winner's gnt only when m_req=1 and m_ready=1 in the same cycle, and move to OWN_winner on that edge.
REQ-014 SHALL leave the state unchanged and assert no gnt when m_ready=0; the requester holds its request.
REQ-015 SHALL, in OWN_x with m_rvalid=1, pass m_rdata to x_rdata and pulse x_rvalid for one cycle with zero added latency; writes also produce an x_rvalid acknowledge.
REQ-016 SHALL, on the m_rvalid cycle, return to IDLE or move directly to the new OWN state if a new grant occurs (back-to-back, no bubble).
REQ-017 SHALL never issue m_req in OWN_x before m_rvalid arrives.
REQ-018 SHALL treat m_rvalid=1 in IDLE as spurious: ignored, no rvalid output.
REQ-019 SHALL grant at most one requester per cycle, so i_gnt and d_gnt are never both 1.

Reset
REQ-020 SHALL, on rst=1, immediately set state=IDLE, the starvation counter to 0, and all outputs to 0 (gnt, rvalid, m_req, m_we, m_be, m_addr, m_wdata, rdata).
REQ-021 SHALL drop any pending response when reset is asserted mid-transaction; a later m_rvalid lands in IDLE and is handled per REQ-018.

Configuration
REQ-022 SHALL include a starvation guard when MEM_ARB_STARVE_GUARD_EN is defined:
- A counter increments each arbitration cycle where i_req=1 and data wins.
- The counter clears on i_gnt.
- At STARVE_LIMIT the counter saturates and fetch wins the next arbitration.
REQ-023 SHALL, without MEM_ARB_STARVE_GUARD_EN, use strict data priority with no counter logic.

Structure
REQ-024 SHALL place the state enum (IDLE/OWN_I/OWN_D) and the default widths in shared package mem_arb_pkg.
REQ-025 SHALL, when the guard is enabled, implement it as sub-module mem_arb_starve_ctr (inputs: deny, grant; output: force); all other logic is flat.

Verification
REQ-026 SHALL cover fetch only: i_req=1, i_addr=0x44, m_ready=1, m_rvalid one cycle later with 0x00000013 -> i_gnt pulse, then i_rvalid=1, i_rdata=0x00000013.
REQ-027 SHALL cover simultaneous requests: i_req=d_req=1 in IDLE -> d_gnt first; i_gnt on the d_rvalid cycle, back-to-back.
REQ-028 SHALL cover a data write: d_we=1, d_be=0x3, d_addr=0x1000, d_wdata=0xDEADBEEF -> memory sees the same values with m_we=1; d_rvalid ack; i_rvalid=0.
REQ-029 SHALL cover backpressure: m_ready=0 for 3 cycles with i_req held -> no gnt, m_req=1 throughout; grant in the cycle m_ready=1.
REQ-030 SHALL cover reset mid-transaction: rst pulsed in OWN_D, then m_rvalid=1 -> outputs are 0 and d_rvalid stays 0.
REQ-031 SHALL, with the guard enabled, cover starvation: d_req held at 1 and i_req=1 with STARVE_LIMIT=4 -> i_gnt on the 5th arbitration cycle.
